// File: rtl/bumpy_state_ctrl.sv
// Motion-state sequencer for the Bumpy ball: turns keypad levels and collision
// pulses into one motion state per video frame and tracks bounce/death timing and lives.
module bumpy_state_ctrl #(
    parameter int BOUNCE_FRAMES = 8,
    parameter int DIE_FRAMES    = 30,
    parameter int LIVES_INIT    = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       col_left,
    input  logic       col_right,
    input  logic       col_top,
    input  logic       col_hazard,
    input  logic       restart,
    output logic [3:0] state,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       die_pulse
);

    localparam int MAX_FRAMES = (BOUNCE_FRAMES > DIE_FRAMES) ? BOUNCE_FRAMES : DIE_FRAMES;
    localparam int CNT_W      = ($clog2(MAX_FRAMES) > 5) ? $clog2(MAX_FRAMES) : 5;

    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] DIE_LOAD    = CNT_W'(DIE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [2:0]       LIVES_LOAD  = 3'(LIVES_INIT);

    localparam logic [3:0] S_RESET       = 4'd0;
    localparam logic [3:0] S_IDLE        = 4'd1;
    localparam logic [3:0] S_LEFT        = 4'd2;
    localparam logic [3:0] S_RIGHT       = 4'd3;
    localparam logic [3:0] S_DOWN        = 4'd4;
    localparam logic [3:0] S_UP          = 4'd5;
    localparam logic [3:0] S_DIE         = 4'd6;
    localparam logic [3:0] S_BOUNCE_LEFT = 4'd7;
    localparam logic [3:0] S_BOUNCE_RIGHT = 4'd8;
    localparam logic [3:0] S_BOUNCE_TOP  = 4'd9;

    logic             pend_left, pend_right, pend_top, pend_hazard;
    logic             hit_left, hit_right, hit_top, hit_hazard;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       state_next;
    logic [2:0]       lives_next;
    logic             game_over_next, die_pulse_next;
    logic             do_restart;

    // A pulse arriving on the frame clock itself counts in that frame.
    assign hit_left   = pend_left   | col_left;
    assign hit_right  = pend_right  | col_right;
    assign hit_top    = pend_top    | col_top;
    assign hit_hazard = pend_hazard | col_hazard;
    assign do_restart = game_over & restart;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        lives_next     = lives;
        game_over_next = game_over;
        die_pulse_next = 1'b0;
        if (do_restart) begin
            state_next     = S_RESET;
            cnt_next       = CNT_ZERO;
            lives_next     = LIVES_LOAD;
            game_over_next = 1'b0;
        end else if (startOfFrame) begin
            case (state)
                S_RESET: begin
                    state_next = S_IDLE;
                    cnt_next   = CNT_ZERO;
                end
                S_IDLE, S_LEFT, S_RIGHT, S_DOWN, S_UP: begin
                    if (hit_hazard)     state_next = S_DIE;
                    else if (hit_top)   state_next = S_BOUNCE_TOP;
                    else if (hit_left)  state_next = S_BOUNCE_LEFT;
                    else if (hit_right) state_next = S_BOUNCE_RIGHT;
                    else if (key_up)    state_next = S_UP;
                    else if (key_down)  state_next = S_DOWN;
                    else if (key_left)  state_next = S_LEFT;
                    else if (key_right) state_next = S_RIGHT;
                    else                state_next = S_IDLE;
                end
                S_BOUNCE_LEFT, S_BOUNCE_RIGHT, S_BOUNCE_TOP: begin
                    // Only a hit on a different side restarts the bounce.
                    if (hit_hazard)                                state_next = S_DIE;
                    else if (hit_top   && state != S_BOUNCE_TOP)   state_next = S_BOUNCE_TOP;
                    else if (hit_left  && state != S_BOUNCE_LEFT)  state_next = S_BOUNCE_LEFT;
                    else if (hit_right && state != S_BOUNCE_RIGHT) state_next = S_BOUNCE_RIGHT;
                    else if (cnt == CNT_ZERO)                      state_next = S_IDLE;
                    else                                           cnt_next   = cnt - 1'b1;
                end
                S_DIE: begin
                    if (cnt != CNT_ZERO)         cnt_next       = cnt - 1'b1;
                    else if (lives != 3'd0)      state_next     = S_RESET;
                    else                         game_over_next = 1'b1;
                end
                default: begin
                    state_next = S_RESET;
                    cnt_next   = CNT_ZERO;
                end
            endcase

            if (state_next != state) begin
                if (state_next == S_DIE) begin
                    cnt_next       = DIE_LOAD;
                    lives_next     = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    die_pulse_next = 1'b1;
                end else if (state_next == S_BOUNCE_LEFT || state_next == S_BOUNCE_RIGHT ||
                             state_next == S_BOUNCE_TOP) begin
                    cnt_next = BOUNCE_LOAD;
                end else begin
                    cnt_next = CNT_ZERO;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_RESET;
            cnt       <= CNT_ZERO;
            lives     <= LIVES_LOAD;
            game_over <= 1'b0;
            die_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            lives     <= lives_next;
            game_over <= game_over_next;
            die_pulse <= die_pulse_next;
        end
    end

    // Pending collisions live until the next frame decision or a restart.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_left   <= 1'b0;
            pend_right  <= 1'b0;
            pend_top    <= 1'b0;
            pend_hazard <= 1'b0;
        end else if (startOfFrame || do_restart) begin
            pend_left   <= 1'b0;
            pend_right  <= 1'b0;
            pend_top    <= 1'b0;
            pend_hazard <= 1'b0;
        end else begin
            pend_left   <= pend_left   | col_left;
            pend_right  <= pend_right  | col_right;
            pend_top    <= pend_top    | col_top;
            pend_hazard <= pend_hazard | col_hazard;
        end
    end

endmodule
